// File: rtl/conv_bram_sequencer.sv
// Drives one conv_layer run through its external BRAM port: load banks, start, wait done, read result bank.
// Optional watchdog on the done wait is enabled by defining CONV_TIMEOUT_EN.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | waiting for go
// LOAD      | accepting source words, one BRAM write per handshake
// START     | conv_start high for one cycle; conv_done already sampled
// WAIT_DONE | waiting for conv_done
// RD_ADDR   | result-bank address on the port
// RD_DATA   | BRAM returns data, captured into res_data
// RD_OUT    | res_valid held until the sink accepts
// FINISH    | run_done pulse
// ERR       | watchdog expired, held until reset (CONV_TIMEOUT_EN only)
module conv_bram_sequencer #(
  parameter int DWIDTH         = 16,
  parameter int MAT_MUL_SIZE   = 4,
  parameter int AWIDTH         = 10,
  parameter int NUM_LOAD_BANKS = 2,
  parameter int LOAD_WORDS     = 16,
  parameter int RESULT_SEL     = 2,
  parameter int RESULT_WORDS   = 16,
  parameter int BASE_ADDR      = 0,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic                           go,
  output logic                           busy,
  output logic                           run_done,
  input  logic                           src_valid,
  output logic                           src_ready,
  input  logic [MAT_MUL_SIZE*DWIDTH-1:0] src_data,
  output logic                           res_valid,
  input  logic                           res_ready,
  output logic [MAT_MUL_SIZE*DWIDTH-1:0] res_data,
  output logic [7:0]                     bram_select,
  output logic [AWIDTH-1:0]              bram_addr_ext,
  output logic [MAT_MUL_SIZE*DWIDTH-1:0] bram_wdata_ext,
  output logic [MAT_MUL_SIZE-1:0]        bram_we_ext,
  input  logic [MAT_MUL_SIZE*DWIDTH-1:0] bram_rdata_ext,
  output logic                           conv_start,
  input  logic                           conv_done
`ifdef CONV_TIMEOUT_EN
  ,
  output logic                           timeout_err
`endif
);

  localparam int W  = MAT_MUL_SIZE * DWIDTH;
  localparam int BW = (NUM_LOAD_BANKS > 1) ? $clog2(NUM_LOAD_BANKS) : 1;

  localparam logic [BW-1:0]     LAST_B = BW'(NUM_LOAD_BANKS - 1);
  localparam logic [AWIDTH-1:0] LAST_W = AWIDTH'(LOAD_WORDS - 1);
  localparam logic [AWIDTH-1:0] LAST_R = AWIDTH'(RESULT_WORDS - 1);
  localparam logic [AWIDTH-1:0] BASE   = AWIDTH'(BASE_ADDR);

  if (LOAD_WORDS < 1 || LOAD_WORDS > (1 << AWIDTH)) begin : g_bad_load_words
    $error("LOAD_WORDS out of range");
  end
  if (RESULT_WORDS < 1 || RESULT_WORDS > (1 << AWIDTH)) begin : g_bad_result_words
    $error("RESULT_WORDS out of range");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  typedef enum logic [3:0] {
    IDLE,
    LOAD,
    START,
    WAIT_DONE,
    RD_ADDR,
    RD_DATA,
    RD_OUT,
    FINISH
`ifdef CONV_TIMEOUT_EN
    ,
    ERR
`endif
  } state_t;

  state_t            state, state_n;
  logic [BW-1:0]     b, b_n;
  logic [AWIDTH-1:0] w, w_n;
  logic [AWIDTH-1:0] r, r_n;

  logic [7:0]              sel_n;
  logic [AWIDTH-1:0]       addr_n;
  logic [W-1:0]            wdata_n;
  logic [MAT_MUL_SIZE-1:0] we_n;
  logic [W-1:0]            res_data_n;
  logic                    res_valid_n;

`ifdef CONV_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  // Loaded in START so the terminal count lands on the last allowed WAIT_DONE cycle.
  localparam logic [TW-1:0] TMO_INIT = TW'(TIMEOUT_CYCLES - 2);
  logic [TW-1:0] tmo_cnt, tmo_n;
`endif

  always_comb begin
    state_n     = state;
    b_n         = b;
    w_n         = w;
    r_n         = r;
    sel_n       = bram_select;
    addr_n      = bram_addr_ext;
    wdata_n     = bram_wdata_ext;
    we_n        = '0;
    res_data_n  = res_data;
    res_valid_n = res_valid;
`ifdef CONV_TIMEOUT_EN
    tmo_n       = tmo_cnt;
`endif

    case (state)
      IDLE: begin
        if (go) begin
          state_n = LOAD;
          b_n     = '0;
          w_n     = '0;
        end
      end
      LOAD: begin
        if (src_valid && src_ready) begin
          sel_n   = 8'(b);
          addr_n  = BASE + w;
          wdata_n = src_data;
          we_n    = '1;
          if (w == LAST_W) begin
            w_n = '0;
            if (b == LAST_B) state_n = START;
            else             b_n     = b + BW'(1);
          end else begin
            w_n = w + AWIDTH'(1);
          end
        end
      end
      START: begin
        r_n = '0;
`ifdef CONV_TIMEOUT_EN
        tmo_n = TMO_INIT;
`endif
        state_n = conv_done ? RD_ADDR : WAIT_DONE;
      end
      WAIT_DONE: begin
        if (conv_done) begin
          state_n = RD_ADDR;
        end
`ifdef CONV_TIMEOUT_EN
        else if (tmo_cnt == '0) begin
          state_n = ERR;
        end else begin
          tmo_n = tmo_cnt - TW'(1);
        end
`endif
      end
      RD_ADDR: state_n = RD_DATA;
      RD_DATA: begin
        res_data_n  = bram_rdata_ext;
        res_valid_n = 1'b1;
        state_n     = RD_OUT;
      end
      RD_OUT: begin
        if (res_ready) begin
          res_valid_n = 1'b0;
          r_n         = r + AWIDTH'(1);
          state_n     = (r == LAST_R) ? FINISH : RD_ADDR;
        end
      end
      FINISH: state_n = IDLE;
`ifdef CONV_TIMEOUT_EN
      ERR: state_n = ERR;
`endif
      default: state_n = IDLE;
    endcase

    // Address is registered on entry so it is on the port during RD_ADDR itself.
    if (state_n == RD_ADDR) begin
      sel_n  = 8'(RESULT_SEL);
      addr_n = BASE + r_n;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state          <= IDLE;
      b              <= '0;
      w              <= '0;
      r              <= '0;
      busy           <= 1'b0;
      run_done       <= 1'b0;
      src_ready      <= 1'b0;
      res_valid      <= 1'b0;
      res_data       <= '0;
      bram_select    <= '0;
      bram_addr_ext  <= '0;
      bram_wdata_ext <= '0;
      bram_we_ext    <= '0;
      conv_start     <= 1'b0;
`ifdef CONV_TIMEOUT_EN
      tmo_cnt        <= '0;
      timeout_err    <= 1'b0;
`endif
    end else begin
      state          <= state_n;
      b              <= b_n;
      w              <= w_n;
      r              <= r_n;
      busy           <= (state_n != IDLE);
      run_done       <= (state_n == FINISH);
      src_ready      <= (state_n == LOAD);
      res_valid      <= res_valid_n;
      res_data       <= res_data_n;
      bram_select    <= sel_n;
      bram_addr_ext  <= addr_n;
      bram_wdata_ext <= wdata_n;
      bram_we_ext    <= we_n;
      conv_start     <= (state_n == START);
`ifdef CONV_TIMEOUT_EN
      tmo_cnt        <= tmo_n;
      timeout_err    <= (state_n == ERR);
`endif
    end
  end

endmodule

// File: tb/tb_conv_bram_sequencer.sv
// Directed bench for conv_bram_sequencer: BRAM model, load/readback logs, immediate-assert checks.
// The watchdog scenario runs only when CONV_TIMEOUT_EN is defined.
module tb_conv_bram_sequencer;
  localparam int W  = 64;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          resetn, go, src_valid, res_ready, conv_done;
  logic [W-1:0]  src_data;
  logic          busy, run_done, src_ready, res_valid, conv_start;
  logic [W-1:0]  res_data, bram_wdata_ext, bram_rdata_ext;
  logic [7:0]    bram_select;
  logic [AW-1:0] bram_addr_ext;
  logic [3:0]    bram_we_ext;
`ifdef CONV_TIMEOUT_EN
  logic          timeout_err;
`endif

  int checks   = 0;
  int failures = 0;

  conv_bram_sequencer #(
    .DWIDTH(16), .MAT_MUL_SIZE(4), .AWIDTH(AW), .NUM_LOAD_BANKS(2), .LOAD_WORDS(4),
    .RESULT_SEL(2), .RESULT_WORDS(16), .BASE_ADDR(0), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .resetn(resetn), .go(go), .busy(busy), .run_done(run_done),
    .src_valid(src_valid), .src_ready(src_ready), .src_data(src_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .bram_select(bram_select), .bram_addr_ext(bram_addr_ext),
    .bram_wdata_ext(bram_wdata_ext), .bram_we_ext(bram_we_ext),
    .bram_rdata_ext(bram_rdata_ext), .conv_start(conv_start), .conv_done(conv_done)
`ifdef CONV_TIMEOUT_EN
    , .timeout_err(timeout_err)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] res_word(input int i);
    return {16'hC0DE, 16'(i), 16'(i * 7 + 3), 16'hBEEF ^ 16'(i)};
  endfunction

  logic [W-1:0]  res_mem [16];
  logic [7:0]    wr_sel  [$];
  logic [AW-1:0] wr_addr [$];
  logic [W-1:0]  wr_data [$];
  logic [W-1:0]  res_log [$];
  int            bad_we    = 0;
  int            start_cnt = 0;

  always @(posedge clk) begin
    if (bram_we_ext != 4'h0) begin
      wr_sel.push_back(bram_select);
      wr_addr.push_back(bram_addr_ext);
      wr_data.push_back(bram_wdata_ext);
      if (bram_we_ext != 4'hF) bad_we++;
    end
    if (res_valid && res_ready) res_log.push_back(res_data);
    if (conv_start) start_cnt++;
    bram_rdata_ext <= (bram_select == 8'd2) ? res_mem[bram_addr_ext[3:0]] : '0;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    wr_sel.delete(); wr_addr.delete(); wr_data.delete(); res_log.delete();
    bad_we = 0; start_cnt = 0;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    tick(); tick();
    resetn = 1'b1;
    clear_logs();
  endtask

  task automatic kick();
    go = 1'b1;
    tick();
    go = 1'b0;
    chk("go_busy", busy, 1);
    chk("go_src_ready", src_ready, 1);
  endtask

  task automatic load_words(input logic [W-1:0] base, input int n, input bit toggle);
    int idx = 0;
    int cyc = 0;
    bit hs;
    while (idx < n && cyc < 64) begin
      src_valid = toggle ? (cyc % 2 == 0) : 1'b1;
      src_data  = base + W'(idx);
      hs = src_valid && src_ready;
      tick();
      if (hs) idx++;
      cyc++;
    end
    chk("load_count", idx, n);
  endtask

  task automatic check_writes(input logic [W-1:0] base, input string tag);
    chk({tag, "_wr_count"}, wr_sel.size(), 8);
    chk({tag, "_bad_we"}, bad_we, 0);
    for (int i = 0; i < 8 && i < wr_sel.size(); i++)
      chk({tag, "_wr"}, {wr_sel[i], wr_addr[i], wr_data[i]},
          {8'(i / 4), AW'(i % 4), base + W'(i)});
  endtask

  task automatic read_out(input bit stall3, output int cyc);
    cyc = 0;
    res_ready = 1'b1;
    while (!run_done && cyc < 400) begin
      if (stall3 && res_valid && res_log.size() == 3) begin
        res_ready = 1'b0;
        repeat (5) begin
          tick(); cyc++;
          chk("stall_valid", res_valid, 1);
          chk("stall_data", res_data, res_word(3));
          chk("stall_addr", bram_addr_ext, 3);
        end
        res_ready = 1'b1;
      end
      tick(); cyc++;
    end
    chk("run_done_seen", run_done, 1);
    chk("res_count", res_log.size(), 16);
    for (int i = 0; i < 16 && i < res_log.size(); i++)
      chk("res_word", res_log[i], res_word(i));
    tick();
    res_ready = 1'b0;
    chk("finish_idle_busy", busy, 0);
    chk("finish_run_done_low", run_done, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timed out");
  end

  initial begin
    int cyc;
    for (int i = 0; i < 16; i++) res_mem[i] = res_word(i);
    go = 0; src_valid = 0; src_data = '0; res_ready = 0; conv_done = 0;

    // Reset state
    do_reset();
    chk("rst_busy", busy, 0);
    chk("rst_outs", {run_done, src_ready, res_valid, conv_start, bram_we_ext}, 0);
    chk("rst_bus", {bram_select, bram_addr_ext, bram_wdata_ext, res_data}, 0);

    // Basic run: src always valid, done 10 cycles after start
    kick();
    load_words(64'd1, 8, 1'b0);
    src_valid = 1'b0;
    chk("basic_start_pulse", conv_start, 1);
    chk("basic_src_ready_drop", src_ready, 0);
    go = 1'b1;
    tick();
    go = 1'b0;
    chk("basic_start_one_cycle", conv_start, 0);
    chk("go_ignored_busy", src_ready, 0);
    repeat (8) tick();
    conv_done = 1'b1;
    tick();
    conv_done = 1'b0;
    chk("basic_rd_sel", bram_select, 2);
    chk("basic_rd_addr0", bram_addr_ext, 0);
    read_out(1'b0, cyc);
    chk("basic_throughput", cyc, 48);
    chk("basic_start_count", start_cnt, 1);
    check_writes(64'd1, "basic");

    // Toggling src_valid
    clear_logs();
    kick();
    load_words(64'h100, 8, 1'b1);
    src_valid = 1'b0;
    repeat (3) tick();
    conv_done = 1'b1;
    tick();
    conv_done = 1'b0;
    read_out(1'b0, cyc);
    check_writes(64'h100, "toggle");

    // Done coincident with start, plus a 5-cycle sink stall on word 3
    clear_logs();
    kick();
    load_words(64'h200, 8, 1'b0);
    src_valid = 1'b0;
    conv_done = 1'b1;
    chk("samecyc_start", conv_start, 1);
    tick();
    conv_done = 1'b0;
    chk("samecyc_rd_sel", bram_select, 2);
    chk("samecyc_rd_addr", bram_addr_ext, 0);
    read_out(1'b1, cyc);
    chk("stall_throughput", cyc, 53);

    // Reset during LOAD at word 2 of bank 1
    clear_logs();
    kick();
    load_words(64'h300, 6, 1'b0);
    resetn = 1'b0;
    tick();
    chk("midrst_busy", busy, 0);
    chk("midrst_outs", {run_done, src_ready, res_valid, conv_start, bram_we_ext}, 0);
    chk("midrst_bus", {bram_select, bram_addr_ext, bram_wdata_ext}, 0);
    resetn = 1'b1;
    src_valid = 1'b0;
    tick();
    chk("midrst_wr_count", wr_sel.size(), 6);
    clear_logs();
    kick();
    src_valid = 1'b1;
    src_data  = 64'h400;
    tick();
    src_valid = 1'b0;
    chk("restart_first_wr", {bram_we_ext, bram_select, bram_addr_ext, bram_wdata_ext},
        {4'hF, 8'd0, 10'd0, 64'h400});
    do_reset();

`ifdef CONV_TIMEOUT_EN
    // Watchdog: conv_done never arrives
    kick();
    load_words(64'h500, 8, 1'b0);
    src_valid = 1'b0;
    chk("tmo_start", conv_start, 1);
    cyc = 0;
    while (!timeout_err && cyc < 40) begin
      tick(); cyc++;
    end
    chk("tmo_latency", cyc, 16);
    go = 1'b1;
    repeat (3) tick();
    go = 1'b0;
    chk("tmo_hold", {timeout_err, busy, src_ready}, 3'b110);
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    chk("tmo_cleared", {timeout_err, busy}, 2'b00);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
